// File: rtl/hack_io_pkg.sv
//==============================================================================
// hack_io_pkg : shared constants and types for Hack memory-mapped I/O blocks
// Revision    : 1.0
//==============================================================================
`default_nettype none

package hack_io_pkg;
   localparam int          HACK_WORD_W   = 16;
   localparam logic [15:0] KBD_NONE      = 16'h0000;
   localparam int          OVF_DROP      = 0;
   localparam int          OVF_OVERWRITE = 1;

   // Per-cycle FIFO operation, encoded as {push, pop}
   typedef enum logic [1:0] {
      FIFO_IDLE     = 2'b00,
      FIFO_POP      = 2'b01,
      FIFO_PUSH     = 2'b10,
      FIFO_PUSH_POP = 2'b11
   } fifo_op_e;
endpackage

`default_nettype wire

// File: rtl/hack_fifo_ptr.sv
//==============================================================================
// hack_fifo_ptr : wrapping pointer register with increment enable
// Revision      : 1.0
//==============================================================================
`default_nettype none

module hack_fifo_ptr #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] ptr
);
   logic [W-1:0] ptr_q;
   logic [W-1:0] ptr_d;

   // Width of W bits makes DEPTH-1 -> 0 wrap implicit
   always_comb begin
      ptr_d = ptr_q;
      if (inc) ptr_d = ptr_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;
endmodule

`default_nettype wire

// File: rtl/hack_keyboard_fifo.sv
//==============================================================================
// hack_keyboard_fifo : DEPTH-entry keycode queue for Hack keyboard MMIO
// Revision           : 1.0
//==============================================================================
`default_nettype none

module hack_keyboard_fifo
   import hack_io_pkg::*;
#(
   parameter int WIDTH      = HACK_WORD_W,
   parameter int DEPTH      = 8,
   parameter int OVF_POLICY = OVF_DROP
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load,
   input  logic [WIDTH-1:0]       in,
   input  logic                   ack,
   input  logic                   clr_ovf,
   output logic [WIDTH-1:0]       out,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;
   logic [AW-1:0]    wrptr, rdptr;
   logic             wr_en, wr_inc, rd_inc;
   logic             push, pop;
   logic             is_empty, is_full;
   fifo_op_e         op;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CW'(DEPTH));

   // Zero keycodes mean "no key" and never enter the queue
   assign push = load && (in != '0);
   assign pop  = ack && !is_empty;
   assign op   = fifo_op_e'({push, pop});

   always_comb begin
      wr_en      = 1'b0;
      wr_inc     = 1'b0;
      rd_inc     = 1'b0;
      count_d    = count_q;
      overflow_d = clr_ovf ? 1'b0 : overflow_q;
      case (op)
         FIFO_PUSH_POP: begin
            wr_en  = 1'b1;
            wr_inc = 1'b1;
            rd_inc = 1'b1;
         end
         FIFO_PUSH: begin
            if (!is_full) begin
               wr_en   = 1'b1;
               wr_inc  = 1'b1;
               count_d = count_q + CW'(1);
            end else begin
               overflow_d = 1'b1;
               // Overwrite policy evicts the oldest entry to make room
               if (OVF_POLICY == OVF_OVERWRITE) begin
                  wr_en  = 1'b1;
                  wr_inc = 1'b1;
                  rd_inc = 1'b1;
               end
            end
         end
         FIFO_POP: begin
            rd_inc  = 1'b1;
            count_d = count_q - CW'(1);
         end
         default: ;
      endcase
   end

   always_comb begin
      mem_d = mem_q;
      if (wr_en) mem_d[wrptr] = in;
   end

   // Storage is intentionally not reset; empty masks stale contents
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   hack_fifo_ptr #(.W(AW)) u_wrptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (wr_inc),
      .ptr   (wrptr)
   );

   hack_fifo_ptr #(.W(AW)) u_rdptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (rd_inc),
      .ptr   (rdptr)
   );

   assign out      = is_empty ? WIDTH'(KBD_NONE) : mem_q[rdptr];
   assign empty    = is_empty;
   assign full     = is_full;
   assign count    = count_q;
   assign overflow = overflow_q;
endmodule

`default_nettype wire

// File: tb/tb_hack_keyboard_fifo.sv
//==============================================================================
// tb_hack_keyboard_fifo : drop and overwrite instances against a queue model
// Revision              : 1.0
//==============================================================================
`default_nettype none

module tb_hack_keyboard_fifo;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic [15:0] din = 16'h0;
   logic        ack = 1'b0;
   logic        clr_ovf = 1'b0;

   logic [15:0] out0, out1;
   logic        empty0, empty1, full0, full1, ovf0, ovf1;
   logic [3:0]  count0, count1;

   int checks = 0;
   int errors = 0;

   logic [15:0] q0[$];
   logic [15:0] q1[$];
   logic        m_ovf0 = 1'b0;
   logic        m_ovf1 = 1'b0;

   always #5 clk = ~clk;

   hack_keyboard_fifo #(.WIDTH(16), .DEPTH(DEPTH), .OVF_POLICY(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .load(load), .in(din), .ack(ack), .clr_ovf(clr_ovf),
      .out(out0), .empty(empty0), .full(full0), .count(count0), .overflow(ovf0)
   );

   hack_keyboard_fifo #(.WIDTH(16), .DEPTH(DEPTH), .OVF_POLICY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .load(load), .in(din), .ack(ack), .clr_ovf(clr_ovf),
      .out(out1), .empty(empty1), .full(full1), .count(count1), .overflow(ovf1)
   );

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check(input string tag);
      logic [15:0] e0, e1;
      e0 = (q0.size() > 0) ? q0[0] : 16'h0;
      e1 = (q1.size() > 0) ? q1[0] : 16'h0;
      cmp({tag, ".out0"},   {16'h0, out0},   {16'h0, e0});
      cmp({tag, ".count0"}, {28'h0, count0}, q0.size());
      cmp({tag, ".empty0"}, {31'h0, empty0}, {31'h0, q0.size() == 0});
      cmp({tag, ".full0"},  {31'h0, full0},  {31'h0, q0.size() == DEPTH});
      cmp({tag, ".ovf0"},   {31'h0, ovf0},   {31'h0, m_ovf0});
      cmp({tag, ".out1"},   {16'h0, out1},   {16'h0, e1});
      cmp({tag, ".count1"}, {28'h0, count1}, q1.size());
      cmp({tag, ".empty1"}, {31'h0, empty1}, {31'h0, q1.size() == 0});
      cmp({tag, ".full1"},  {31'h0, full1},  {31'h0, q1.size() == DEPTH});
      cmp({tag, ".ovf1"},   {31'h0, ovf1},   {31'h0, m_ovf1});
   endtask

   // Queue semantics: pop first, then push; a push into a full queue is an overflow
   task automatic model_update();
      logic p;
      p = load && (din != 16'h0);
      if (clr_ovf) begin
         m_ovf0 = 1'b0;
         m_ovf1 = 1'b0;
      end
      if (ack && q0.size() > 0) void'(q0.pop_front());
      if (ack && q1.size() > 0) void'(q1.pop_front());
      if (p) begin
         if (q0.size() < DEPTH) q0.push_back(din);
         else m_ovf0 = 1'b1;
         if (q1.size() < DEPTH) q1.push_back(din);
         else begin
            m_ovf1 = 1'b1;
            void'(q1.pop_front());
            q1.push_back(din);
         end
      end
   endtask

   task automatic step(input logic l, input logic [15:0] d, input logic a,
                       input logic c, input string tag);
      load = l; din = d; ack = a; clr_ovf = c;
      @(posedge clk);
      model_update();
      #1;
      check(tag);
      load = 1'b0; din = 16'h0; ack = 1'b0; clr_ovf = 1'b0;
   endtask

   task automatic model_reset();
      q0.delete();
      q1.delete();
      m_ovf0 = 1'b0;
      m_ovf1 = 1'b0;
   endtask

   initial begin
      // Power-on reset
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset");
      rst_n = 1'b1;
      step(0, 16'h0, 0, 0, "idle");

      // Three queued, then asynchronous reset between edges
      step(1, 16'h0041, 0, 0, "pushA");
      step(1, 16'h0042, 0, 0, "pushB");
      step(1, 16'h0043, 0, 0, "pushC");
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("async_reset");
      cmp("async_reset.out_const", {16'h0, out0}, 32'h0);
      #3 rst_n = 1'b1;

      // Ordered push then drain
      step(1, 16'h0041, 0, 0, "pushA2");
      cmp("first_word_latency", {16'h0, out0}, 32'h41);
      step(1, 16'h0042, 0, 0, "pushB2");
      step(1, 16'h0043, 0, 0, "pushC2");
      cmp("count_three", {28'h0, count0}, 32'd3);
      for (int i = 0; i < 3; i++) step(0, 16'h0, 1, 0, "drain");
      cmp("drained_out", {16'h0, out0}, 32'h0);

      // Ignored operations
      step(1, 16'h0000, 0, 0, "load_zero");
      step(0, 16'h0000, 1, 0, "ack_empty");
      step(1, 16'h0077, 1, 0, "push_pop_empty");
      step(0, 16'h0, 1, 0, "pop_single");

      // Overflow: nine pushes into eight entries
      for (int i = 1; i <= 9; i++) step(1, 16'(i), 0, 0, "fill9");
      cmp("drop_head", {16'h0, out0}, 32'h1);
      cmp("overwrite_head", {16'h0, out1}, 32'h2);
      for (int i = 0; i < 8; i++) step(0, 16'h0, 1, 0, "drain9");

      // Full with simultaneous push and pop: no overflow
      step(0, 16'h0, 0, 1, "clr_ovf");
      for (int i = 1; i <= 8; i++) step(1, 16'(16'h10 + i), 0, 0, "fill8");
      step(1, 16'h0055, 1, 0, "full_push_pop");
      cmp("full_push_pop.ovf_const", {31'h0, ovf0}, 32'h0);
      for (int i = 0; i < 7; i++) step(0, 16'h0, 1, 0, "drain_pre55");
      cmp("last_is_55", {16'h0, out0}, 32'h55);
      step(0, 16'h0, 1, 0, "drain55");

      // Overflow concurrent with clr_ovf: set wins
      for (int i = 1; i <= 8; i++) step(1, 16'(16'h20 + i), 0, 0, "fill8b");
      step(1, 16'h0099, 0, 1, "ovf_and_clr");
      cmp("ovf_and_clr.const", {31'h0, ovf0}, 32'h1);
      step(0, 16'h0, 0, 1, "clr_alone");
      cmp("clr_alone.const", {31'h0, ovf1}, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic        l, a, c;
         logic [15:0] d;
         l = ($urandom_range(0, 2) != 0);
         a = ($urandom_range(0, 2) == 0);
         c = ($urandom_range(0, 15) == 0);
         d = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom_range(1, 65535));
         step(l, d, a, c, "random");
      end

      // Final reset
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("final_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: observed running expected finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end
endmodule

`default_nettype wire
